// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its downstream execution unit.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        OUT   = 2'd3
    } exec_state_t;

endpackage

// File: rtl/instr_exec_div.sv
// Serial 32-bit signed restoring divider, one quotient bit per cycle after a load cycle.
// Present only when INSTR_EXEC_DIV_EN is defined.
`ifdef INSTR_EXEC_DIV_EN
module instr_exec_div (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [31:0]  dividend,
    input  logic signed [31:0]  divisor,
    output logic                done,
    output logic signed [32:0]  quotient,
    output logic signed [31:0]  remainder
);

    logic        busy_q, busy_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;

    logic [31:0] a_raw, b_raw, a_mag, b_mag;
    logic [32:0] rem_shift, diff;
    logic        fits;
    logic [31:0] rem_step, quo_step;
    logic signed [32:0] q_mag;
    logic signed [31:0] r_mag;

    always_comb begin
        a_raw     = dividend;
        b_raw     = divisor;
        a_mag     = a_raw[31] ? (~a_raw + 32'd1) : a_raw;
        b_mag     = b_raw[31] ? (~b_raw + 32'd1) : b_raw;

        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        fits      = ~diff[32];
        rem_step  = fits ? diff[31:0] : rem_shift[31:0];
        quo_step  = {quo_q[30:0], fits};

        // Results are taken from the final iteration's step values so the
        // caller can register them on the same edge the last bit resolves.
        done      = busy_q && (cnt_q == 6'd1);
        q_mag     = {1'b0, quo_step};
        r_mag     = rem_step;
        quotient  = neg_q_q ? -q_mag : q_mag;
        remainder = neg_r_q ? -r_mag : r_mag;

        busy_d  = busy_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = 6'd32;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            neg_q_d = a_raw[31] ^ b_raw[31];
            neg_r_d = a_raw[31];
        end else if (busy_q) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            cnt_d  = cnt_q - 6'd1;
            busy_d = (cnt_q != 6'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
    end

endmodule
`endif

// File: rtl/instr_exec_unit.sv
// Walks the instruction register over a range and streams one computed result per instruction.
// INSTR_EXEC_DIV_EN enables the serial divider for DIV/MOD; otherwise they report res_err.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     first_ptr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      result,
    output address_t     res_addr,
    output logic         res_err,
    output logic         busy,
    output logic         done
);

    localparam address_t LAST_ADDR = address_t'(NUM_REGS - 1);

    exec_state_t  state_q, state_d;
    address_t     rp_q, rp_d;
    logic [5:0]   remaining_q, remaining_d;
    instruction_t instr_q, instr_d;
    result_t      result_q, result_d;
    address_t     res_addr_q, res_addr_d;
    logic         res_err_q, res_err_d;
    logic         res_valid_q, res_valid_d;
    logic         done_q, done_d;

    result_t      alu_res;
    logic         alu_err;
    result_t      a64, b64;

`ifdef INSTR_EXEC_DIV_EN
    logic               div_wait_q, div_wait_d;
    logic               div_start, div_done;
    logic signed [32:0] div_quo;
    logic signed [31:0] div_rem;
    logic               div_needed;

    instr_exec_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (instr_q.op_a),
        .divisor   (instr_q.op_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    always_comb begin
        a64     = {{32{instr_q.op_a[31]}}, instr_q.op_a};
        b64     = {{32{instr_q.op_b[31]}}, instr_q.op_b};
        alu_res = '0;
        alu_err = 1'b0;
        case (instr_q.opc)
            ZERO:     alu_res = '0;
            PASSA:    alu_res = a64;
            PASSB:    alu_res = b64;
            ADD:      alu_res = a64 + b64;
            SUB:      alu_res = a64 - b64;
            MULT:     alu_res = a64 * b64;
            // Reached only for a zero divisor, or when the divider is absent.
            DIV, MOD: alu_err = 1'b1;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rp_d        = rp_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        result_d    = result_q;
        res_addr_d  = res_addr_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
`ifdef INSTR_EXEC_DIV_EN
        div_wait_d  = div_wait_q;
        div_start   = 1'b0;
        div_needed  = ((instr_q.opc == DIV) || (instr_q.opc == MOD)) && (instr_q.op_b != '0);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        rp_d        = first_ptr;
                        remaining_d = count;
                        state_d     = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                instr_d    = instruction_word;
                res_addr_d = rp_q;
                state_d    = EXEC;
            end
            EXEC: begin
`ifdef INSTR_EXEC_DIV_EN
                if (div_needed) begin
                    if (!div_wait_q) begin
                        div_start  = 1'b1;
                        div_wait_d = 1'b1;
                    end else if (div_done) begin
                        div_wait_d  = 1'b0;
                        result_d    = (instr_q.opc == DIV) ? {{31{div_quo[32]}}, div_quo}
                                                           : {{32{div_rem[31]}}, div_rem};
                        res_err_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                end else begin
                    result_d    = alu_res;
                    res_err_d   = alu_err;
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end
`else
                result_d    = alu_res;
                res_err_d   = alu_err;
                res_valid_d = 1'b1;
                state_d     = OUT;
`endif
            end
            OUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (remaining_q > 6'd1) begin
                        rp_d        = (rp_q == LAST_ADDR) ? '0 : rp_q + 5'd1;
                        remaining_d = remaining_q - 6'd1;
                        state_d     = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rp_q        <= '0;
            remaining_q <= '0;
            result_q    <= '0;
            res_addr_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef INSTR_EXEC_DIV_EN
            div_wait_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rp_q        <= rp_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
            res_addr_q  <= res_addr_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
`ifdef INSTR_EXEC_DIV_EN
            div_wait_q  <= div_wait_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    assign read_pointer = rp_q;
    assign res_valid    = res_valid_q;
    assign result       = result_q;
    assign res_addr     = res_addr_q;
    assign res_err      = res_err_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit; expectations follow INSTR_EXEC_DIV_EN if defined.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    address_t     first_ptr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      result;
    address_t     res_addr;
    logic         res_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.NUM_REGS(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_ptr        (first_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_addr         (res_addr),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t t;
        t.opc  = o;
        t.op_a = a;
        t.op_b = b;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rp"},    64'(read_pointer), 64'd0);
        chk({tag, "_vld"},   64'(res_valid),    64'd0);
        chk({tag, "_res"},   result,            64'd0);
        chk({tag, "_addr"},  64'(res_addr),     64'd0);
        chk({tag, "_err"},   64'(res_err),      64'd0);
        chk({tag, "_busy"},  64'(busy),         64'd0);
        chk({tag, "_done"},  64'(done),         64'd0);
    endtask

    task automatic do_start(input address_t p, input logic [5:0] c);
        start     = 1'b1;
        first_ptr = p;
        count     = c;
        step();
        start     = 1'b0;
    endtask

    // Waits for res_valid, counting edges from the call, then checks the result.
    task automatic expect_result(input string tag, input result_t exp_res, input address_t exp_addr,
                                 input logic exp_err, input int exp_lat);
        int cyc = 0;
        while (cyc < 60) begin
            step();
            cyc++;
            if (res_valid) break;
        end
        if (!res_valid) begin
            chk({tag, "_timeout"}, 64'(res_valid), 64'd1);
            return;
        end
        chk({tag, "_lat"},  64'(cyc),          64'(exp_lat));
        chk({tag, "_res"},  result,            exp_res);
        chk({tag, "_addr"}, 64'(res_addr),     64'(exp_addr));
        chk({tag, "_rp"},   64'(read_pointer), 64'(exp_addr));
        chk({tag, "_err"},  64'(res_err),      64'(exp_err));
    endtask

    task automatic finish_run(input string tag);
        step();
        chk({tag, "_done"},  64'(done),      64'd1);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_vld"},   64'(res_valid), 64'd0);
        step();
        chk({tag, "_done_clr"}, 64'(done),   64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);
        reset     = 1'b1;
        start     = 1'b0;
        first_ptr = '0;
        count     = '0;
        res_ready = 1'b1;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // Single ADD
        mem[0] = mk(ADD, 7, -3);
        do_start(5'd0, 6'd1);
        chk("add_rp0",   64'(read_pointer), 64'd0);
        chk("add_busy",  64'(busy),         64'd1);
        expect_result("add", 64'sd4, 5'd0, 1'b0, 2);
        finish_run("add");

        // Zero-length run
        do_start(5'd3, 6'd0);
        chk("cnt0_done", 64'(done), 64'd1);
        chk("cnt0_busy", 64'(busy), 64'd0);
        step();
        chk("cnt0_done_clr", 64'(done), 64'd0);

        // Back-to-back sequence
        mem[0] = mk(MULT, -15, 15);
        mem[1] = mk(SUB, 0, 15);
        mem[2] = mk(PASSB, 9, -1);
        do_start(5'd0, 6'd3);
        expect_result("mult",  -64'sd225, 5'd0, 1'b0, 2);
        expect_result("sub",   -64'sd15,  5'd1, 1'b0, 3);
        expect_result("passb", -64'sd1,   5'd2, 1'b0, 3);
        finish_run("seq");

        // Wrapping range
        mem[30] = mk(ADD, 1, 2);
        mem[31] = mk(SUB, 5, 10);
        mem[0]  = mk(PASSA, -100, 4);
        do_start(5'd30, 6'd3);
        expect_result("wrap30", 64'sd3,    5'd30, 1'b0, 2);
        expect_result("wrap31", -64'sd5,   5'd31, 1'b0, 3);
        expect_result("wrap0",  -64'sd100, 5'd0,  1'b0, 3);
        finish_run("wrap");

        // Divide / modulo
        mem[4] = mk(DIV, -7, 2);
        mem[5] = mk(MOD, -7, 2);
        mem[6] = mk(DIV, 5, 0);
        mem[7] = mk(DIV, 32'h8000_0000, -1);
        do_start(5'd4, 6'd4);
`ifdef INSTR_EXEC_DIV_EN
        expect_result("div",    -64'sd3,            5'd4, 1'b0, 34);
        expect_result("mod",    -64'sd1,            5'd5, 1'b0, 35);
        expect_result("div0",   64'sd0,             5'd6, 1'b1, 3);
        expect_result("divmin", 64'sh0_8000_0000,   5'd7, 1'b0, 35);
`else
        mem[4] = mk(DIV, 8, 2);
        expect_result("div",    64'sd0, 5'd4, 1'b1, 2);
        expect_result("mod",    64'sd0, 5'd5, 1'b1, 3);
        expect_result("div0",   64'sd0, 5'd6, 1'b1, 3);
        expect_result("divmin", 64'sd0, 5'd7, 1'b1, 3);
`endif
        finish_run("divrun");

        // Backpressure, with an ignored start while busy
        mem[10] = mk(ADD, 100, 23);
        mem[11] = mk(SUB, 1, 1);
        res_ready = 1'b0;
        do_start(5'd10, 6'd2);
        expect_result("hold", 64'sd123, 5'd10, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_vld",  64'(res_valid),    64'd1);
            chk("hold_res",  result,            64'd123);
            chk("hold_addr", 64'(res_addr),     64'd10);
            chk("hold_rp",   64'(read_pointer), 64'd10);
            if (i == 1) begin
                start     = 1'b1;
                first_ptr = 5'd20;
                count     = 6'd1;
            end
            if (i == 2) start = 1'b0;
        end
        res_ready = 1'b1;
        expect_result("hold2", 64'sd0, 5'd11, 1'b0, 3);
        finish_run("hold");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("noqueue_busy", 64'(busy), 64'd0);
        end

        // Asynchronous reset mid-flight
        mem[12] = mk(DIV, 100, 7);
        res_ready = 1'b0;
        do_start(5'd12, 6'd1);
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        #1;
        reset = 1'b0;
        step();
        res_ready = 1'b1;
        do_start(5'd1, 6'd1);
        expect_result("post_rst", -64'sd15, 5'd1, 1'b0, 2);
        finish_run("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

- Downstream consumer of the instruction register.
- When started, it walks the register's read port over a contiguous range of locations and captures each `instruction_word`.
- It executes each opcode on the two signed operands and presents a 64-bit result per instruction on a valid/ready output port.
- It turns the stored instruction stack into a stream of computed results for later checking or storage stages.

## Interface

- `NUM_REGS`, default 32: depth of the instruction register; the read pointer wraps modulo this value.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to execute a range; sampled only in IDLE.
- `first_ptr`  in  `address_t` (5)  first location to execute; captured on start.
- `count`  in  6  number of instructions, 0..32; captured on start.
- `read_pointer`  out  `address_t` (5)  drives the instruction register read address.
- `instruction_word`  in  `instruction_t`  combinational read data for `read_pointer`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `result`  out  `result_t` (64, signed)  computed value.
- `res_addr`  out  `address_t` (5)  location the result came from.
- `res_err`  out  1  result invalid: divide by zero, or DIV/MOD compiled out.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation

- States: IDLE, FETCH, EXEC, OUT.
- IDLE:
  - `start`=1 with `count`>0 → `read_pointer`<=`first_ptr`, remaining<=`count`, go to FETCH.
  - `start`=1 with `count`=0 → `done` pulses the next cycle and the state stays IDLE.
- FETCH: capture `instruction_word` into an internal register; `res_addr`<=`read_pointer`; go to EXEC.
- EXEC: compute the result; register `result` and `res_err`, set `res_valid`=1, go to OUT.
- OUT: hold `result`, `res_addr` and `res_err` stable while `res_valid`=1 and `res_ready`=0. On a cycle with `res_valid`&&`res_ready`:
  - remaining>1 → clear `res_valid`, `read_pointer`<=(`read_pointer`+1) mod `NUM_REGS`, decrement remaining, go to FETCH.
  - remaining=1 → clear `res_valid`, pulse `done`, go to IDLE.
- `start` while `busy` is ignored; it is not queued.
- The range wraps: `first_ptr`=30, `count`=4 executes locations 30, 31, 0, 1.
- Arithmetic: `op_a` and `op_b` are signed 32-bit; results are sign-extended to 64 bits.
  - ZERO → 0.
  - PASSA → `op_a`.
  - PASSB → `op_b`.
  - ADD → `op_a`+`op_b`.
  - SUB → `op_a`−`op_b`.
  - MULT → full 64-bit signed product.
  - DIV → quotient truncated toward zero.
  - MOD → remainder with the sign of `op_a`.
  - No overflow is possible in 64 bits. The single exception is DIV of −2^31 by −1, which gives +2^31 exactly.
- `op_b`=0 on DIV/MOD → `result`=0, `res_err`=1, single-cycle EXEC.
- Reset in any state returns the unit to IDLE immediately. All outputs take their reset values, and any in-flight instruction or division is discarded.

## Timing

- Reset values: `read_pointer`=0, `res_valid`=0, `result`=0, `res_addr`=0, `res_err`=0, `busy`=0, `done`=0.
- Edge numbering: edge 0 is the edge that samples `start`. `read_pointer` shows `first_ptr` from edge 0, FETCH occupies edge 0→1, EXEC occupies edge 1→2, and `res_valid` is high from edge 2.
- Throughput with `res_ready` held at 1: one result per 3 cycles for non-divide opcodes.
- DIV/MOD with nonzero divisor: EXEC lasts 33 cycles (1 setup cycle plus 32 iteration cycles); `res_valid` rises 34 cycles after FETCH begins.
- `done` is high for exactly the cycle after the final handshake edge; `busy` is already 0 in that cycle.

## Configuration

- Macro: `INSTR_EXEC_DIV_EN`.
- Defined: DIV/MOD are handled by the serial restoring divider, with the latency given above.
- Undefined: DIV/MOD complete in a single-cycle EXEC with `result`=0 and `res_err`=1. No divider logic is present.

## Structure

- `instr_register_pkg` gains `result_t` (signed 64-bit) and the exec state enum. `opcode_t`, `operand_t`, `address_t` and `instruction_t` are reused as they are.
- Sub-module `instr_exec_div`: serial 32-bit signed divider with a start/done handshake. It returns the quotient and remainder and is instantiated only under `INSTR_EXEC_DIV_EN`.

## Test plan

- Load location 0 with ADD, a=7, b=−3. Pulse `start` with `first_ptr`=0, `count`=1 → `result`=4, `res_addr`=0, `res_err`=0, `done` pulses once, `res_valid` high at edge 2.
- Load locations 0..2 with MULT a=−15, b=15; SUB a=0, b=15; PASSB a=9, b=−1. Run `count`=3 with `res_ready`=1 → results −225, −15, −1 at 3-cycle spacing.
- Drive `first_ptr`=30, `count`=3 → `read_pointer` sequence 30, 31, 0; `res_addr` values match.
- Run DIV a=−7, b=2 and MOD a=−7, b=2 with the macro defined → −3 and −1, each after 33 EXEC cycles. Run DIV b=0 → 0 with `res_err`=1 after 1 EXEC cycle. Without the macro, DIV a=8, b=2 → 0 with `res_err`=1.
- Hold `res_ready`=0 for 5 cycles → `result` and `res_addr` stay stable and `read_pointer` does not advance. A `start` issued meanwhile is ignored.
- Assert `reset` during a DIV in EXEC → all outputs return to their reset values asynchronously; after release the unit accepts a new `start`.
